// File: rtl/hdc_assoc_mem.sv
// Hamming-distance associative memory: chunked XOR/popcount against all
// prototypes in parallel, then a sequential argmin with a one-cycle done pulse.
// Ports: clk, nrst (async low), en/hv_in query start, class_hvs prototypes,
// busy, out pulse, class_out (nearest index), dist_out (its distance).
module hdc_assoc_mem #(
  parameter int DIMENSIONS  = 6,
  parameter int PAR_BITS    = 2,
  parameter int NUM_CLASSES = 2,
  localparam int DW = $clog2(DIMENSIONS + 1),
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   en,
  input  logic [DIMENSIONS-1:0]                  hv_in,
  input  logic [NUM_CLASSES-1:0][DIMENSIONS-1:0] class_hvs,
  output logic                                   busy,
  output logic                                   out,
  output logic [CW-1:0]                          class_out,
  output logic [DW-1:0]                          dist_out
);

  localparam int N_CHUNKS = (DIMENSIONS + PAR_BITS - 1) / PAR_BITS;
  localparam int KW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int PW = N_CHUNKS * PAR_BITS;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    SELECT
  } state_t;

  state_t state, state_nx;

  logic [DIMENSIONS-1:0] hv_q;
  logic [KW-1:0]         chunk_cnt;
  logic [CW-1:0]         sel_cnt;
  logic [DW-1:0]         acc [NUM_CLASSES];
  logic [DW-1:0]         pc  [NUM_CLASSES];
  logic [DW-1:0]         best_d, cand_d, sel_d;
  logic [CW-1:0]         best_c, cand_c;
  logic                  last_chunk, last_sel;

  // Zero-extended diff split into chunks; pad bits stay 0,
  // which masks the out-of-range part of the last chunk.
  logic [N_CHUNKS-1:0][PAR_BITS-1:0] dpad;
  logic [PAR_BITS-1:0]               chunk;

  assign last_chunk = (chunk_cnt == KW'(N_CHUNKS - 1));
  assign last_sel   = (sel_cnt == CW'(NUM_CLASSES - 1));
  assign busy       = (state != IDLE);

  always_comb begin
    dpad  = '0;
    chunk = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      dpad  = PW'(hv_q ^ class_hvs[c]);
      chunk = dpad[chunk_cnt];
      pc[c] = '0;
      for (int b = 0; b < PAR_BITS; b++) begin
        pc[c] = pc[c] + DW'(chunk[b]);
      end
    end
  end

  // Class 0 seeds the running best; strict < keeps the lowest index on ties.
  always_comb begin
    sel_d  = acc[sel_cnt];
    cand_d = best_d;
    cand_c = best_c;
    if (sel_cnt == '0 || sel_d < best_d) begin
      cand_d = sel_d;
      cand_c = sel_cnt;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = COMPARE;
      COMPARE: if (last_chunk) state_nx = SELECT;
      SELECT:  if (last_sel) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hv_q      <= '0;
      chunk_cnt <= '0;
      sel_cnt   <= '0;
      best_d    <= '0;
      best_c    <= '0;
      out       <= 1'b0;
      class_out <= '0;
      dist_out  <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
    end else begin
      out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            hv_q      <= hv_in;
            chunk_cnt <= '0;
            sel_cnt   <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
          end
        end
        COMPARE: begin
          for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= acc[c] + pc[c];
          chunk_cnt <= chunk_cnt + 1'b1;
        end
        SELECT: begin
          best_d  <= cand_d;
          best_c  <= cand_c;
          sel_cnt <= sel_cnt + 1'b1;
          if (last_sel) begin
            class_out <= cand_c;
            dist_out  <= cand_d;
            out       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
